// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_stage_pkg;

  typedef enum logic [1:0] {FETCH, WAIT, HOLD, HALT} if_state_t;

  localparam logic [5:0]  OPC_HALT = 6'b010001;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  function automatic logic is_halt(input logic [31:0] inst);
    return inst[31:26] == OPC_HALT;
  endfunction

endpackage

// File: rtl/if_hold_buf.sv
// One-entry buffer parking a fetched word while ID is stalled.
module if_hold_buf
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  logic [31:0] load_inst,
  input  logic [31:0] load_pc4,
  output logic [31:0] inst,
  output logic [31:0] pc4,
  output logic        valid
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      inst  <= NOP_INST;
      pc4   <= RESET_PC;
    end else if (clear || drain) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      inst  <= load_inst;
      pc4   <= load_pc4;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Fetch stage: one outstanding imem read, stall hold buffer, redirect flush, HALT parking.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_stage
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        branch_taken_f_ex,
  input  logic [31:0] branch_target_f_ex,
  input  logic        stall_f_hz,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_2_id,
  output logic [31:0] pc4_2_id,
  output logic        valid_2_id,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
);

  if_state_t   state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        flush;
  logic        take_word;
  logic        deliver;
  logic        hb_load;
  logic        hb_drain;
  logic        hb_valid;
  logic [31:0] hb_inst;
  logic [31:0] hb_pc4;
  logic [31:0] src_inst;
  logic [31:0] src_pc4;

  assign pc_plus4 = pc + 32'd4;

  // Reset is folded in so the request is quiet during reset yet live right after release.
  assign imem_req  = reset & (state == FETCH);
  assign imem_addr = imem_req ? pc : RESET_PC;

  always_comb begin
    take_word = (state == WAIT) && !flush && imem_rvalid && !branch_taken_f_ex;
    hb_load   = take_word && stall_f_hz;
    hb_drain  = hb_valid && !stall_f_hz && !branch_taken_f_ex;
    deliver   = hb_drain || (take_word && !stall_f_hz);
    src_inst  = hb_valid ? hb_inst : imem_rdata;
    src_pc4   = hb_valid ? hb_pc4 : pc_plus4;
  end

  if_hold_buf u_hold_buf (
    .clk       (clk),
    .reset     (reset),
    .load      (hb_load),
    .drain     (hb_drain),
    .clear     (branch_taken_f_ex),
    .load_inst (imem_rdata),
    .load_pc4  (pc_plus4),
    .inst      (hb_inst),
    .pc4       (hb_pc4),
    .valid     (hb_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      flush      <= 1'b0;
      inst_2_id  <= NOP_INST;
      pc4_2_id   <= RESET_PC;
      valid_2_id <= 1'b0;
    end else begin
      if (deliver) begin
        inst_2_id  <= src_inst;
        pc4_2_id   <= src_pc4;
        valid_2_id <= 1'b1;
      end else if (branch_taken_f_ex || !stall_f_hz) begin
        inst_2_id  <= NOP_INST;
        valid_2_id <= 1'b0;
      end

      if (branch_taken_f_ex) begin
        pc <= branch_target_f_ex;
        // A read still in flight must be drained and dropped before fetching the target.
        if (state == FETCH || (state == WAIT && !imem_rvalid)) begin
          state <= WAIT;
          flush <= 1'b1;
        end else begin
          state <= FETCH;
          flush <= 1'b0;
        end
      end else begin
        unique case (state)
          FETCH: state <= WAIT;
          WAIT: begin
            if (imem_rvalid) begin
              if (flush) begin
                flush <= 1'b0;
                state <= FETCH;
              end else begin
                pc <= pc_plus4;
                if (stall_f_hz)              state <= HOLD;
                else if (is_halt(imem_rdata)) state <= HALT;
                else                          state <= FETCH;
              end
            end
          end
          HOLD: begin
            if (!stall_f_hz) state <= is_halt(hb_inst) ? HALT : FETCH;
          end
          HALT: state <= HALT;
        endcase
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt  <= 32'h0;
      bubble_cnt <= 32'h0;
    end else begin
      if (deliver)     fetch_cnt  <= fetch_cnt + 32'd1;
      if (!valid_2_id) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`else
  assign fetch_cnt  = 32'h0;
  assign bubble_cnt = 32'h0;
`endif

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have ports (name  direction  width  meaning): clk  in  1  clock; all state on rising edge.
REQ-002 reset  in  1  asynchronous, active-low reset.
REQ-003 branch_taken_f_ex  in  1  single-cycle redirect pulse from EX.
REQ-004 branch_target_f_ex  in  32  redirect PC; valid while branch_taken_f_ex=1.
REQ-005 stall_f_hz  in  1  hazard stall; holds the IF/ID register.
REQ-006 imem_req  out  1  instruction-memory read request, one cycle per fetch.
REQ-007 imem_addr  out  32  fetch address; valid while imem_req=1.
REQ-008 imem_rvalid  in  1  read-data strobe, at least 1 cycle after imem_req.
REQ-009 imem_rdata  in  32  instruction word; valid while imem_rvalid=1.
REQ-010 inst_2_id  out  32  registered instruction to ID.
REQ-011 pc4_2_id  out  32  registered fetch PC + 4 to ID.
REQ-012 valid_2_id  out  1  1 = inst_2_id is a real fetched instruction.
REQ-013 fetch_cnt  out  32  count of instructions delivered to ID (see REQ-031).
REQ-014 bubble_cnt  out  32  count of cycles valid_2_id=0 (see REQ-031).

Function
REQ-015 FSM states SHALL be FETCH, WAIT, HOLD, HALT; FETCH entered on reset release.
REQ-016 FETCH: imem_req=1, imem_addr=pc; next state WAIT unconditionally; exactly one request outstanding.
REQ-017 WAIT: imem_req=0; on imem_rvalid=1 and stall_f_hz=0, at the edge: inst_2_id<=imem_rdata, pc4_2_id<=pc+4, valid_2_id<=1, pc<=pc+4; next FETCH.
REQ-018 WAIT with imem_rvalid=1 and stall_f_hz=1: capture imem_rdata and pc+4 into hold buffer, pc<=pc+4, IF/ID register unchanged; next HOLD.
REQ-019 HOLD: no requests; first cycle stall_f_hz=0, hold buffer moves to IF/ID register with valid_2_id=1; next FETCH.
REQ-020 Delivered word with opcode [31:26]=6'b010001 (HALT): next state HALT instead of FETCH; HALT issues no requests; valid_2_id<=0 and inst_2_id<=32'h0 from the next unstalled cycle.
REQ-021 Cycles with no delivery and stall_f_hz=0: inst_2_id<=32'h0000_0000 (bubble, add r0,r0,r0), valid_2_id<=0, pc4_2_id held.
REQ-022 stall_f_hz=1 and no redirect: inst_2_id, pc4_2_id, valid_2_id SHALL hold.
REQ-023 branch_taken_f_ex=1 SHALL take priority over stall, delivery and HALT: pc<=branch_target_f_ex, hold buffer discarded, IF/ID register<=bubble (valid_2_id=0), next FETCH.
REQ-024 Redirect in WAIT: set flush flag, stay WAIT; returned word discarded (no delivery, pc not incremented); flag cleared; next FETCH at target.
REQ-025 Redirect in HALT SHALL exit to FETCH at target (HALT was wrong-path).
REQ-026 imem_rvalid outside WAIT SHALL be ignored.
REQ-027 PC arithmetic 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 32'h0; branch_target bits [1:0] used as given.

Reset
REQ-028 reset=0 SHALL asynchronously set pc=32'h0, state FETCH, flush flag 0, hold buffer empty, inst_2_id=32'h0, pc4_2_id=32'h0, valid_2_id=0, imem_req=0, imem_addr=32'h0, counters 0.
REQ-029 Reset mid-request SHALL abandon the outstanding fetch; a late imem_rvalid is ignored per REQ-026.
REQ-030 First request SHALL appear in the first cycle after reset deasserts, at addr 32'h0.

Configuration
REQ-031 Macro IF_PERF_CNT_EN: defined -> fetch_cnt increments per delivery to ID, bubble_cnt increments per cycle valid_2_id=0 after reset, both wrap at 2^32; undefined -> counters not built, ports tied to 32'h0.

Structure
REQ-032 Shared struct package SHALL hold if_state_t enum, OPC_HALT=6'b010001, NOP_INST=32'h0000_0000, RESET_PC=32'h0.
REQ-033 Hold buffer SHALL be sub-module if_hold_buf (one entry: 32-bit inst, 32-bit pc4, valid; load, drain, clear).

Verification
REQ-034 Reset release, memory returns 32'h0400_0005 after 1 cycle -> imem_addr 0, then inst_2_id=32'h0400_0005, pc4_2_id=4, valid_2_id=1; next request addr 4.
REQ-035 stall_f_hz=1 across return of 32'h1000_0001 at pc 8 -> IF/ID holds, no request while stalled; stall drop -> inst_2_id=32'h1000_0001, pc4_2_id=12.
REQ-036 Branch to 32'h40 while in WAIT at pc 16 -> returned word dropped, next imem_addr=32'h40, valid_2_id=0 for that slot.
REQ-037 Fetch 32'h4400_0000 (HALT) -> no further imem_req; branch to 32'h80 -> request at 32'h80.
REQ-038 Branch and stall asserted in same cycle as rvalid in HOLD -> bubble out, buffer discarded, fetch at target.
REQ-039 reset pulsed during WAIT, rvalid arrives after release -> ignored; fetch restarts at 32'h0; with IF_PERF_CNT_EN counters read 0.
